// File: rtl/fracnet_mac_accum_if.sv
// Product-in / activation-out bundle between the scaling multiplier, the accumulator and its consumer.
interface fracnet_mac_accum_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_last;
  logic                    in_ready;
  logic signed [15:0]      bias;
  logic        [4:0]       shift;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready;
  logic                    ovf;

  modport master (
    output in_valid, in_data, in_last, bias, shift, out_ready,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, bias, shift, out_ready,
    output in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/fracnet_mac_accum.sv
// Group accumulator: sum signed products, add bias, round-half-up shift, saturate to OUT_W.
// FRACNET_ACC_SAT_EN: saturating accumulator with sticky ovf; otherwise wrap and ovf stays 0.
module fracnet_mac_accum #(
  parameter int IN_W  = 24,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  fracnet_mac_accum_if.slave bus
);
  typedef enum logic [1:0] {ACC, ROUND, OUT} state_t;

  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_sum;
  logic        [4:0]       r_shift;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_in_ready;
  logic                    r_ovf;

  logic                    w_accept;
  logic signed [ACC_W-1:0] w_data_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_sum_nxt;
  logic                    w_clamp;

  // r_in_ready is only high in ACC, so it doubles as the state qualifier
  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_data_ext = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
  assign w_bias_ext = {{(ACC_W-16){bus.bias[15]}}, bus.bias};

`ifdef FRACNET_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] w_add_a;
  logic signed [ACC_W:0] w_add_b;
  logic                  w_clamp_a;
  logic                  w_clamp_b;

  always_comb begin
    w_add_a   = {r_acc[ACC_W-1], r_acc} + {w_data_ext[ACC_W-1], w_data_ext};
    w_clamp_a = w_add_a[ACC_W] ^ w_add_a[ACC_W-1];
    w_acc_nxt = w_clamp_a ? (w_add_a[ACC_W] ? ACC_MIN : ACC_MAX) : w_add_a[ACC_W-1:0];
    w_add_b   = {w_acc_nxt[ACC_W-1], w_acc_nxt} + {w_bias_ext[ACC_W-1], w_bias_ext};
    w_clamp_b = w_add_b[ACC_W] ^ w_add_b[ACC_W-1];
    w_sum_nxt = w_clamp_b ? (w_add_b[ACC_W] ? ACC_MIN : ACC_MAX) : w_add_b[ACC_W-1:0];
    w_clamp   = w_clamp_a || (bus.in_last && w_clamp_b);
  end
`else
  assign w_acc_nxt = r_acc + w_data_ext;
  assign w_sum_nxt = w_acc_nxt + w_bias_ext;
  assign w_clamp   = 1'b0;
`endif

  logic signed [ACC_W:0]   w_sum_x;
  logic signed [ACC_W:0]   w_half;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [OUT_W-1:0] w_sat;

  // One extra bit of headroom keeps the half-LSB add from wrapping
  always_comb begin
    w_sum_x = {r_sum[ACC_W-1], r_sum};
    w_half  = '0;
    if (r_shift != 5'd0) w_half = (ACC_W+1)'(1) << (r_shift - 5'd1);
    w_rnd = (w_sum_x + w_half) >>> r_shift;
    if (w_rnd > OUT_MAX)      w_sat = OUT_MAX[OUT_W-1:0];
    else if (w_rnd < OUT_MIN) w_sat = OUT_MIN[OUT_W-1:0];
    else                      w_sat = w_rnd[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_sum       <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            r_ovf <= r_ovf | w_clamp;
            if (bus.in_last) begin
              r_sum      <= w_sum_nxt;
              r_shift    <= bus.shift;
              r_acc      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= ROUND;
            end else begin
              r_acc <= w_acc_nxt;
            end
          end
        end
        ROUND: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fracnet_mac_accum.sv
// Bench for fracnet_mac_accum: directed corner groups plus random groups against an arithmetic model.
module tb_fracnet_mac_accum;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fracnet_mac_accum_if #(.IN_W(24), .OUT_W(16)) bus_a ();
  fracnet_mac_accum_if #(.IN_W(24), .OUT_W(16)) bus_b ();

  fracnet_mac_accum #(.IN_W(24), .ACC_W(32), .OUT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fracnet_mac_accum #(.IN_W(24), .ACC_W(26), .OUT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

`ifdef FRACNET_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int g_beats [16];
  bit m_ovf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, wrapped or clamped to w bits
  function automatic longint fixw(input longint x, input int w, input bit sat);
    longint lo, hi, m;
    lo = -(longint'(1) <<< (w-1));
    hi = -lo - 1;
    m  = longint'(1) <<< w;
    if (sat) begin
      if (x > hi) begin m_ovf = 1'b1; return hi; end
      if (x < lo) begin m_ovf = 1'b1; return lo; end
      return x;
    end
    return ((x - lo) % m + m) % m + lo;
  endfunction

  function automatic longint model(input int n, input int bias, input int sh, input int w, input bit sat);
    longint acc, s, r;
    acc   = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < n-1; i++) acc = fixw(acc + g_beats[i], w, sat);
    s = fixw(fixw(acc + g_beats[n-1], w, sat) + bias, w, sat);
    if (sh == 0) r = s;
    else         r = (s + (longint'(1) <<< (sh-1))) >>> sh;
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic garbage_a();
    logic [23:0] d;
    d = $urandom;
    bus_a.in_valid = 1'($urandom_range(0, 1));
    bus_a.in_data  = d;
    bus_a.in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_a(input int n, input int bias, input int sh, input int gap_max, input bit has_last);
    int gap, cnt;
    logic [15:0] rb;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, gap_max);
      repeat (gap) begin
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = 24'($urandom);
        tick();
      end
      rb = $urandom;
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = g_beats[i][23:0];
      bus_a.in_last  = has_last && (i == n-1);
      bus_a.bias     = bus_a.in_last ? 16'(bias) : rb;
      bus_a.shift    = bus_a.in_last ? 5'(sh) : 5'($urandom);
      cnt = 0;
      while (!bus_a.in_ready && cnt < 50) begin tick(); cnt++; end
      chk("beat_rdy", bus_a.in_ready, 1);
      tick();
    end
  endtask

  task automatic recv_a(input int exp, input int exp_ovf, input int stall, input bit chk_lat);
    int cnt;
    chk("rdy_round", bus_a.in_ready, 0);
    cnt = 0;
    while (!bus_a.out_valid && cnt < 20) begin garbage_a(); tick(); cnt++; end
    chk("out_vld", bus_a.out_valid, 1);
    if (chk_lat) chk("latency", cnt, 1);
    repeat (stall) begin
      garbage_a();
      bus_a.out_ready = 1'b0;
      tick();
      chk("hold_vld", bus_a.out_valid, 1);
      chk("hold_dat", bus_a.out_data, exp);
      chk("hold_rdy", bus_a.in_ready, 0);
    end
    bus_a.out_ready = 1'b1;
    chk("out_dat", bus_a.out_data, exp);
    chk("ovf", bus_a.ovf, exp_ovf);
    tick();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b0;
    chk("hs_vld", bus_a.out_valid, 0);
    chk("hs_rdy", bus_a.in_ready, 1);
    chk("ovf_clr", bus_a.ovf, 0);
  endtask

  initial begin
    int cnt, n, bias, sh, exp, stall;
    logic [23:0] rd;
    logic [15:0] rb;

    reset = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0;
    bus_a.bias = '0; bus_a.shift = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0;
    bus_b.bias = '0; bus_b.shift = '0; bus_b.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", bus_a.in_ready, 1);
    chk("rst_vld", bus_a.out_valid, 0);
    chk("rst_dat", bus_a.out_data, 0);
    chk("rst_ovf", bus_a.ovf, 0);
    chk("rst_b_ovf", bus_b.ovf, 0);
    reset = 1'b1;
    tick();

    // Three-beat group with latency check
    g_beats[0] = 100; g_beats[1] = 200; g_beats[2] = 300;
    send_a(3, 0, 0, 0, 1'b1);
    recv_a(600, 0, 0, 1'b1);

    // Round-half-up ties
    g_beats[0] = 1000;  send_a(1, 0, 4, 0, 1'b1);  recv_a(63, 0, 0, 1'b0);
    g_beats[0] = -1000; send_a(1, 0, 4, 0, 1'b1);  recv_a(-62, 0, 0, 1'b0);
    g_beats[0] = 992;   send_a(1, 16, 4, 0, 1'b1); recv_a(63, 0, 0, 1'b0);

    // Output saturation
    g_beats[0] = 8388607;  g_beats[1] = 8388607;  send_a(2, 0, 0, 0, 1'b1); recv_a(32767, 0, 0, 1'b0);
    g_beats[0] = -8388608; g_beats[1] = -8388608; send_a(2, 0, 0, 0, 1'b1); recv_a(-32768, 0, 0, 1'b0);

    // Backpressure with upstream beats held against in_ready=0
    g_beats[0] = 1234; g_beats[1] = -34;
    send_a(2, -200, 0, 1, 1'b1);
    recv_a(1000, 0, 5, 1'b0);

    // Reset mid-group discards the partial sum
    g_beats[0] = 50; g_beats[1] = 60;
    send_a(2, 0, 0, 0, 1'b0);
    bus_a.in_valid = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    chk("rst_mid_rdy", bus_a.in_ready, 1);
    chk("rst_mid_vld", bus_a.out_valid, 0);
    g_beats[0] = 7; send_a(1, 0, 0, 0, 1'b1); recv_a(7, 0, 0, 1'b0);

    // Reset while the result is held
    g_beats[0] = 500; send_a(1, 0, 0, 0, 1'b1);
    bus_a.in_valid = 1'b0;
    cnt = 0;
    while (!bus_a.out_valid && cnt < 20) begin tick(); cnt++; end
    chk("pre_rst_vld", bus_a.out_valid, 1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst_out_vld", bus_a.out_valid, 0);
    chk("rst_out_dat", bus_a.out_data, 0);
    chk("rst_out_rdy", bus_a.in_ready, 1);
    tick();

    // Random groups with gaps and stalls
    for (int g = 0; g < 40; g++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin rd = $urandom; g_beats[i] = int'($signed(rd)); end
      rb    = $urandom;
      bias  = int'($signed(rb));
      sh    = $urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(4, 14);
      stall = $urandom_range(0, 3);
      exp   = int'(model(n, bias, sh, 32, SAT));
      send_a(n, bias, sh, 2, 1'b1);
      recv_a(exp, int'(m_ovf), stall, 1'b0);
    end

    // Narrow accumulator: clamp or wrap depending on build
    for (int i = 0; i < 8; i++) g_beats[i] = 8388607;
    for (int i = 0; i < 8; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 24'h7FFFFF;
      bus_b.in_last  = (i == 7);
      chk("b_rdy", bus_b.in_ready, 1);
      tick();
    end
    bus_b.in_valid = 1'b0;
    cnt = 0;
    while (!bus_b.out_valid && cnt < 20) begin tick(); cnt++; end
    chk("b_vld", bus_b.out_valid, 1);
    exp = int'(model(8, 0, 0, 26, SAT));
    chk("b_dat", bus_b.out_data, exp);
    chk("b_ovf", bus_b.ovf, m_ovf);
    chk("b_dat_lit", bus_b.out_data, SAT ? 32767 : -8);
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    chk("b_hs_vld", bus_b.out_valid, 0);
    chk("b_ovf_clr", bus_b.ovf, 0);
    chk("b_hs_rdy", bus_b.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
